// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared types and constants for the ROM download loader.
// Holds the FSM state type, the ROM region map and the special download indices.
package rom_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned NREG_MAX = 6;
  localparam int unsigned OFS_W    = 17;

  // Region map in download address space: main, sound, chars, tiles, sprites, proms
  localparam logic [31:0] REG_BASE [NREG_MAX] = '{
    32'h00000, 32'h10000, 32'h12000, 32'h16000, 32'h26000, 32'h36000
  };
  localparam logic [31:0] REG_SIZE [NREG_MAX] = '{
    32'h10000, 32'h02000, 32'h04000, 32'h10000, 32'h10000, 32'h00300
  };

  localparam logic [7:0] ROM_INDEX = 8'd0;
  localparam logic [7:0] MOD_INDEX = 8'd1;
  localparam logic [7:0] DIP_INDEX = 8'd254;

endpackage

// File: rtl/rom_region_dec.sv
// rom_region_dec: combinational decode of a download address into a one-hot
// region select and the byte offset inside that region.
module rom_region_dec
  import rom_loader_pkg::*;
#(
  parameter int unsigned NREG = 6,
  parameter int unsigned AW   = 25
) (
  input  logic [AW-1:0]    addr,
  output logic [NREG-1:0]  region,
  output logic [OFS_W-1:0] offset,
  output logic             out_of_range
);

  logic [31:0] addr_w;

  // Match the address against each region window; regions never overlap
  always_comb begin
    addr_w = 32'(addr);
    region = '0;
    offset = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (addr_w >= REG_BASE[i] && addr_w < (REG_BASE[i] + REG_SIZE[i])) begin
        region[i] = 1'b1;
        offset    = OFS_W'(addr_w - REG_BASE[i]);
      end
    end
    out_of_range = ~|region;
  end

endmodule

// File: rtl/rom_loader.sv
// rom_loader: turns the HPS ioctl download stream into ROM region writes,
// captures DIP switch and PCB-variant bytes, and reports load status.
// Optional feature: define ROM_LOADER_CHECKSUM_EN to produce a 16-bit
// wrapping sum of all written ROM bytes on load_sum (tied to 0 otherwise).
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned NREG = 6,
  parameter int unsigned AW   = 25
) (
  input  logic             clk_sys,
  input  logic             RESET_n,
  input  logic             ioctl_download,
  input  logic             ioctl_wr,
  input  logic [7:0]       ioctl_index,
  input  logic [AW-1:0]    ioctl_addr,
  input  logic [7:0]       ioctl_dout,
  output logic             ioctl_wait,
  input  logic             rom_busy,
  output logic [NREG-1:0]  rom_we,
  output logic [16:0]      rom_addr,
  output logic [7:0]       rom_data,
  output logic [7:0]       dip1,
  output logic [7:0]       dip2,
  output logic             pcb_mod,
  output logic             load_done,
  output logic             load_err,
  output logic [15:0]      load_sum
);

  state_t            state;
  logic              dl_prev;
  logic              entry_valid;
  logic [NREG-1:0]   entry_region;
  logic [NREG-1:0]   dec_region;
  logic [OFS_W-1:0]  dec_offset;
  logic              dec_oor;
  logic              dl_fall;
  logic              start;
  logic              drain;
  logic              rom_wr;
  logic              take;
  logic              err_evt;

  rom_region_dec #(
    .NREG (NREG),
    .AW   (AW)
  ) u_dec (
    .addr         (ioctl_addr),
    .region       (dec_region),
    .offset       (dec_offset),
    .out_of_range (dec_oor)
  );

  // Download edge detection, holding-register handshake and error events
  always_comb begin
    dl_fall = ~ioctl_download & dl_prev;
    start   = ioctl_download & ~dl_prev & (ioctl_index == ROM_INDEX) &
              ((state == IDLE) | (state == DONE));
    drain   = entry_valid & ~rom_busy;
    rom_wr  = ioctl_wr & ioctl_download & (ioctl_index == ROM_INDEX) &
              ((state == LOAD) | start);
    take    = rom_wr & ~dec_oor & (~entry_valid | drain);
    err_evt = rom_wr & (dec_oor | (entry_valid & rom_busy));
  end

  assign ioctl_wait = entry_valid & rom_busy;
  assign rom_we     = drain ? entry_region : '0;

  // Previous download level; resets high so a download already in flight
  // at reset release is not mistaken for a new one
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) dl_prev <= 1'b1;
    else          dl_prev <= ioctl_download;
  end

  // Load sequencing FSM with registered done flag
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= IDLE;
      load_done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            load_done <= 1'b0;
          end
        end
        LOAD: begin
          if (dl_fall) state <= DRAIN;
        end
        DRAIN: begin
          if (!entry_valid) begin
            state     <= DONE;
            load_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-entry holding register; refills in the same cycle it drains
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      entry_valid  <= 1'b0;
      entry_region <= '0;
      rom_addr     <= '0;
      rom_data     <= '0;
    end else if (take) begin
      entry_valid  <= 1'b1;
      entry_region <= dec_region;
      rom_addr     <= dec_offset;
      rom_data     <= ioctl_dout;
    end else if (drain) begin
      entry_valid  <= 1'b0;
    end
  end

  // Sticky error flag, cleared when a new ROM load begins
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n)     load_err <= 1'b0;
    else if (start)   load_err <= err_evt;
    else if (err_evt) load_err <= 1'b1;
  end

  // DIP switch and PCB-variant capture from their own download indices
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      dip1    <= 8'hFF;
      dip2    <= 8'hFF;
      pcb_mod <= 1'b0;
    end else if (ioctl_wr && ioctl_download) begin
      if (ioctl_index == DIP_INDEX && ioctl_addr < AW'(8)) begin
        if (ioctl_addr == AW'(1)) dip1 <= ioctl_dout;
        if (ioctl_addr == AW'(2)) dip2 <= ioctl_dout;
      end
      if (ioctl_index == MOD_INDEX) pcb_mod <= (ioctl_dout == 8'h01);
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  // Wrapping sum of every byte written out; restarts with each ROM load
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n)   load_sum <= '0;
    else if (start) load_sum <= '0;
    else if (drain) load_sum <= load_sum + 16'(rom_data);
  end
`else
  assign load_sum = '0;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: scoreboard bench for rom_loader. Expected ROM writes are queued
// as stimulus is issued; a negedge monitor pops and compares on every rom_we.
module tb_rom_loader;
  import rom_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        rom_busy;
  logic [5:0]  rom_we;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  dip1;
  logic [7:0]  dip2;
  logic        pcb_mod;
  logic        load_done;
  logic        load_err;
  logic [15:0] load_sum;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0]  we;
    logic [16:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q[$];

  rom_loader dut (
    .clk_sys        (clk),
    .RESET_n        (rst_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .rom_busy       (rom_busy),
    .rom_we         (rom_we),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .dip1           (dip1),
    .dip2           (dip2),
    .pcb_mod        (pcb_mod),
    .load_done      (load_done),
    .load_err       (load_err),
    .load_sum       (load_sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] we, input logic [16:0] a, input logic [7:0] d);
    exp_t e;
    e.we = we; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic dl_start(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic dl_end();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (load_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("load_done_reached", 32'(load_done), 32'd1);
  endtask

  // Scoreboard monitor: every rom_we pulse must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rom_we !== 6'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rom_we: got we=%b addr=%h data=%h expected none",
                 rom_we, rom_addr, rom_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rom_we !== e.we || rom_addr !== e.addr || rom_data !== e.data) begin
          errors++;
          $display("FAIL rom_write: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                   rom_we, rom_addr, rom_data, e.we, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    logic [15:0] sum1;
    logic [15:0] sum2;
`ifdef ROM_LOADER_CHECKSUM_EN
    sum1 = 16'h014F;
    sum2 = 16'h00FE;
`else
    sum1 = 16'h0000;
    sum2 = 16'h0000;
`endif
    rst_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'd0;
    ioctl_addr = '0; ioctl_dout = 8'd0; rom_busy = 1'b0;
    #23;
    // Reset values
    chk("rst_rom_we", 32'(rom_we), 32'd0);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_sum", 32'(load_sum), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_data", 32'(rom_data), 32'd0);
    chk("rst_dip1", 32'(dip1), 32'hFF);
    chk("rst_dip2", 32'(dip2), 32'hFF);
    chk("rst_pcb_mod", 32'(pcb_mod), 32'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Basic decode, then back-to-back writes across every region boundary
    dl_start(8'd0);
    chk("load_state", 32'(dut.state), 32'(LOAD));
    push(6'b000100, 17'h00005, 8'hA5);
    wr(25'h12005, 8'hA5);
    chk("first_we", 32'(rom_we), 32'b000100);
    chk("first_addr", 32'(rom_addr), 32'h5);
    chk("first_data", 32'(rom_data), 32'hA5);
    push(6'b000001, 17'h00000, 8'h11);
    push(6'b010000, 17'h0FFFF, 8'h22);
    push(6'b000010, 17'h00000, 8'h33);
    push(6'b100000, 17'h002FF, 8'h44);
    wr(25'h00000, 8'h11);
    wr(25'h35FFF, 8'h22);
    wr(25'h10000, 8'h33);
    wr(25'h362FF, 8'h44);
    tick();
    dl_end();
    wait_done();
    chk("t1_err", 32'(load_err), 32'd0);
    chk("t1_sum", 32'(load_sum), 32'(sum1));

    // Back-pressure for three cycles with a dropped write while blocked
    dl_start(8'd0);
    chk("t2_done_clr", 32'(load_done), 32'd0);
    push(6'b001000, 17'h00001, 8'h5A);
    rom_busy = 1'b1;
    wr(25'h16001, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      chk("bp_wait_hi", 32'(ioctl_wait), 32'd1);
      chk("bp_no_we", 32'(rom_we), 32'd0);
      if (i == 1) begin
        ioctl_wr = 1'b1; ioctl_addr = 25'h16002; ioctl_dout = 8'h77;
      end
      tick();
      ioctl_wr = 1'b0;
    end
    rom_busy = 1'b0;
    #1;
    chk("bp_wait_lo", 32'(ioctl_wait), 32'd0);
    chk("bp_we", 32'(rom_we), 32'b001000);
    chk("bp_drop_err", 32'(load_err), 32'd1);
    tick();
    chk("bp_single_pulse", 32'(rom_we), 32'd0);
    dl_end();
    wait_done();

    // Out-of-range address: no write, sticky error, still completes
    dl_start(8'd0);
    chk("t3_err_clr", 32'(load_err), 32'd0);
    wr(25'h36300, 8'h99);
    chk("oor_no_we", 32'(rom_we), 32'd0);
    chk("oor_err", 32'(load_err), 32'd1);
    dl_end();
    wait_done();
    chk("oor_err_after", 32'(load_err), 32'd1);

    // DIP and PCB-variant downloads
    dl_start(8'd254);
    wr(25'd1, 8'h3C);
    wr(25'd2, 8'h81);
    wr(25'd9, 8'h00);
    wr(25'd0, 8'h55);
    dl_end();
    dl_start(8'd1);
    wr(25'd0, 8'h01);
    dl_end();
    chk("dip1", 32'(dip1), 32'h3C);
    chk("dip2", 32'(dip2), 32'h81);
    chk("pcb_mod", 32'(pcb_mod), 32'd1);
    chk("done_holds", 32'(load_done), 32'd1);

    // Long run of 0xFF bytes exercising the checksum wrap
    dl_start(8'd0);
    for (int i = 0; i < 258; i++) begin
      push(6'b000001, 17'(i), 8'hFF);
      wr(25'(i), 8'hFF);
    end
    tick();
    dl_end();
    wait_done();
    chk("t5_err", 32'(load_err), 32'd0);
    chk("t5_sum", 32'(load_sum), 32'(sum2));

    // Reset in the middle of a load with a blocked pending entry
    dl_start(8'd0);
    rom_busy = 1'b1;
    wr(25'h12000, 8'h66);
    chk("pre_rst_wait", 32'(ioctl_wait), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(rom_we), 32'd0);
    chk("mid_rst_wait", 32'(ioctl_wait), 32'd0);
    chk("mid_rst_dip1", 32'(dip1), 32'hFF);
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    tick();
    rst_n = 1'b1;
    rom_busy = 1'b0;
    tick(); tick(); tick();
    chk("post_rst_idle", 32'(dut.state), 32'(IDLE));
    wr(25'h00000, 8'h12);
    tick();
    chk("ignored_wr_idle", 32'(dut.state), 32'(IDLE));
    dl_end();
    tick();
    chk("post_rst_done", 32'(load_done), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
